gray_conv_stream: RTL and testbench

Parametrised, streaming Gray/binary code converter with a valid/ready handshake and a two-entry output buffer. It generalises the fixed 4-bit combinational Gray-to-binary converter. Each transaction selects its own direction, Gray-to-binary or binary-to-Gray. The block sits between a Gray-coded source, such as a position encoder or an async-FIFO pointer, and binary-domain logic, and provides full throughput under downstream backpressure.

---
 rtl/gray_conv_stream.sv | 144 ++++++++++++++
 tb/tb_gray_conv_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_stream.sv
// Streaming Gray<->binary converter with valid/ready handshake and a two-entry output buffer.
// Optional adjacency check on Gray-mode inputs is enabled by defining GRAY_CONV_ADJ_CHECK_EN.
module gray_conv_stream #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_mode,
  output logic               out_adj_err,
  output logic [COUNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nxt;
  logic             in_acc, out_acc;
  logic             load_out_in, load_out_skid, load_skid;
  logic [WIDTH-1:0] conv_data;
  logic             conv_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_mode, skid_err;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign in_acc    = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign out_acc   = out_valid && out_ready;
  assign conv_data = in_mode ? (in_data ^ (in_data >> 1)) : gray2bin(in_data);

`ifdef GRAY_CONV_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             hist_valid;

  // Consecutive Gray-mode words must differ in exactly one bit; binary words are ignored.
  assign conv_err = !in_mode && hist_valid && ($countones(in_data ^ prev_gray) != 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray  <= '0;
      hist_valid <= 1'b0;
    end else if (in_acc && !in_mode) begin
      prev_gray  <= in_data;
      hist_valid <= 1'b1;
    end
  end
`else
  assign conv_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          state_nxt   = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (in_acc && !out_acc) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (in_acc) begin
          load_out_in = 1'b1;
        end else if (out_acc) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_acc) begin
          state_nxt     = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it drops only once the skid slot is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= (state_nxt != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_mode    <= 1'b0;
      out_adj_err <= 1'b0;
    end else if (load_out_in) begin
      out_data    <= conv_data;
      out_mode    <= in_mode;
      out_adj_err <= conv_err;
    end else if (load_out_skid) begin
      out_data    <= skid_data;
      out_mode    <= skid_mode;
      out_adj_err <= skid_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data <= '0;
      skid_mode <= 1'b0;
      skid_err  <= 1'b0;
    end else if (load_skid) begin
      skid_data <= conv_data;
      skid_mode <= in_mode;
      skid_err  <= conv_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (in_acc && (xfer_count != {COUNT_W{1'b1}})) begin
      xfer_count <= xfer_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_conv_stream.sv
// Directed self-checking bench for gray_conv_stream (WIDTH=4, COUNT_W=4 so saturation is reachable).
module tb_gray_conv_stream;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_mode;
  logic          out_adj_err;
  logic [CW-1:0] xfer_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt;
  logic exp_adj;

  gray_conv_stream #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_adj_err(out_adj_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic m, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef GRAY_CONV_ADJ_CHECK_EN
    exp_adj = 1'b1;
`else
    exp_adj = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_xfer", xfer_count, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_mode", out_mode, 0);
    checkOutput("rst_adj_err", out_adj_err, 0);

    // Single Gray word 0110 -> 0100
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b1);
    tick();
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_data", out_data, 4'b0100);
    checkOutput("single_mode", out_mode, 0);
    checkOutput("single_adj", out_adj_err, 0);
    checkOutput("single_xfer", xfer_count, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("single_drain", out_valid, 0);

    // Binary->Gray sweep, back-to-back; counter saturates at 15
    exp_cnt = 1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, W'(i), 1'b1, 1'b1);
      tick();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      checkOutput("sweep_valid", out_valid, 1);
      checkOutput("sweep_data", out_data, (i ^ (i >> 1)) & 32'hF);
      checkOutput("sweep_mode", out_mode, 1);
      checkOutput("sweep_ready", in_ready, 1);
      checkOutput("sweep_xfer", xfer_count, exp_cnt);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("sweep_drain", out_valid, 0);
    checkOutput("sat_xfer", xfer_count, 15);

    // Mixed modes on 1111: Gray->bin 1010, bin->Gray 1000
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b1111, i[0], 1'b1);
      tick();
      checkOutput("mix_valid", out_valid, 1);
      checkOutput("mix_data", out_data, i[0] ? 4'b1000 : 4'b1010);
      checkOutput("mix_mode", out_mode, i[0]);
      checkOutput("mix_adj", out_adj_err, i[0] ? 1'b0 : exp_adj);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();

    // Backpressure: A=bin 0011->0010, B=bin 0101->0111, C=gray 1000->1111
    applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0);
    tick();
    checkOutput("bp_a_valid", out_valid, 1);
    checkOutput("bp_a_data", out_data, 4'b0010);
    checkOutput("bp_a_ready", in_ready, 1);
    applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0);
    tick();
    checkOutput("bp_b_ready", in_ready, 0);
    checkOutput("bp_b_hold", out_data, 4'b0010);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    tick();
    checkOutput("bp_stall_ready", in_ready, 0);
    checkOutput("bp_stall_data", out_data, 4'b0010);
    checkOutput("bp_stall_mode", out_mode, 1);
    tick();
    checkOutput("bp_stall2_valid", out_valid, 1);
    checkOutput("bp_stall2_data", out_data, 4'b0010);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_rel_data", out_data, 4'b0111);
    checkOutput("bp_rel_ready", in_ready, 1);
    tick();
    checkOutput("bp_c_data", out_data, 4'b1111);
    checkOutput("bp_c_mode", out_mode, 0);
    checkOutput("bp_c_adj", out_adj_err, exp_adj);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("bp_drain", out_valid, 0);

    // Reset while in TWO
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);
    tick();
    checkOutput("mid_two_ready", in_ready, 0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_xfer", xfer_count, 0);
    tick();
    rst = 1'b0;

    // Adjacency sequence after reset: 0000,0001,0011,0000
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("adj0_data", out_data, 4'b0000);
    checkOutput("adj0_valid", out_valid, 1);
    checkOutput("adj0_err", out_adj_err, 0);
    checkOutput("adj0_xfer", xfer_count, 1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    tick();
    checkOutput("adj1_data", out_data, 4'b0001);
    checkOutput("adj1_err", out_adj_err, 0);
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1);
    tick();
    checkOutput("adj2_data", out_data, 4'b0010);
    checkOutput("adj2_err", out_adj_err, 0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("adj3_data", out_data, 4'b0000);
    checkOutput("adj3_err", out_adj_err, exp_adj);
    checkOutput("adj3_xfer", xfer_count, 4);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("final_drain", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
